// File: rtl/bcd_display_scanner_if.sv
// Bus between the BCD converter stage and the display scanner.
// Converter side: load strobe, sign flag, eight BCD digits (first = LSD .. eighth = MSD).
// Display side: seg {g..a} active-low, an active-low digit enables, slot index, sign_ovf.
interface bcd_display_scanner_if;
  logic       load;
  logic       neg;
  logic [3:0] first;
  logic [3:0] second;
  logic [3:0] third;
  logic [3:0] fourth;
  logic [3:0] fifth;
  logic [3:0] sixth;
  logic [3:0] seventh;
  logic [3:0] eighth;
  logic [6:0] seg;
  logic [7:0] an;
  logic [2:0] slot;
  logic       sign_ovf;

  modport master (
    output load, neg, first, second, third, fourth, fifth, sixth, seventh, eighth,
    input  seg, an, slot, sign_ovf
  );

  modport slave (
    input  load, neg, first, second, third, fourth, fifth, sixth, seventh, eighth,
    output seg, an, slot, sign_ovf
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Purpose: holds 8 BCD digits + sign and scans them onto an 8-digit common-anode
//   7-segment display with leading-zero blanking and a floating minus sign.
// Latency: 1 cycle from slot index / held data change to seg/an/slot/sign_ovf pins.
// Backpressure: none; load is accepted on any cycle, including mid-scan.
// Ports: clock, reset (sync, active-high); bus (slave modport): load/neg/first..eighth in,
//   seg/an/slot/sign_ovf out, all outputs registered.
module bcd_display_scanner #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  bcd_display_scanner_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0]   r_presc;
  logic [2:0]      r_slot_idx;
  logic [7:0][3:0] r_digits;
  logic            r_neg;

  logic [6:0]      r_seg;
  logic [7:0]      r_an;
  logic [2:0]      r_slot;
  logic            r_ovf;

  logic            w_tick;
  logic [2:0]      w_msd;
  logic [3:0]      w_cur_digit;
  logic [6:0]      w_seg_nxt;
  logic            w_ovf_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h06;  // non-BCD input shows "E"
    endcase
  endfunction

  assign w_tick      = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_cur_digit = r_digits[r_slot_idx];

  // Most significant non-zero digit; 0 when all digits are zero so "0" stays visible.
  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_digits[i] != 4'd0) w_msd = 3'(i);
    end
  end

  // With msd == 7 there is no slot left for the minus; sign_ovf flags it instead.
  always_comb begin
    w_seg_nxt = 7'h7F;
    if (!BLANK_LEADING || (r_slot_idx <= w_msd)) begin
      w_seg_nxt = glyph(w_cur_digit);
    end else if (r_neg && (w_msd != 3'd7) && (r_slot_idx == w_msd + 3'd1)) begin
      w_seg_nxt = 7'h3F;
    end
  end

  assign w_ovf_nxt = BLANK_LEADING && r_neg && (w_msd == 3'd7);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc    <= '0;
      r_slot_idx <= 3'd0;
      r_digits   <= '0;
      r_neg      <= 1'b0;
      r_seg      <= 7'h7F;
      r_an       <= 8'hFF;
      r_slot     <= 3'd0;
      r_ovf      <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_slot_idx <= r_slot_idx + 3'd1;
      if (bus.load) begin
        r_neg    <= bus.neg;
        r_digits <= {bus.eighth, bus.seventh, bus.sixth, bus.fifth,
                     bus.fourth, bus.third, bus.second, bus.first};
      end
      r_seg  <= w_seg_nxt;
      r_an   <= ~(8'b1 << r_slot_idx);
      r_slot <= r_slot_idx;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign bus.seg      = r_seg;
  assign bus.an       = r_an;
  assign bus.slot     = r_slot;
  assign bus.sign_ovf = r_ovf;

endmodule
